led_sandbox_systick_sequencer: RTL and testbench
================================================

# led_sandbox_systick_sequencer

Avalon-MM master that owns the systick interval timer's 16-bit register slave and runs it without CPU involvement. After reset it programs the timer's 32-bit period and starts it in continuous, interrupt-enabled mode. It then services every timer interrupt by clearing the status register, and converts each timeout into a one-cycle `tick` pulse plus a free-running tick count for the LED logic. It also accepts run-time period changes and enable/disable requests, and sequences the required stop / reprogram / restart writes.

## Interface
Parameters:
- `PERIOD`, 32'd49999: initial period value (timer reload value; 1 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; high = timer must run, low = timer must be stopped.
- `cfg_period`  in  32  new period value, sampled when `cfg_load` is high.
- `cfg_load`  in  1  one-cycle request to reprogram the period.
- `timer_irq`  in  1  irq output of the timer.
- `m_address`  out  3  word address to timer slave.
- `m_chipselect`  out  1  Avalon chipselect.
- `m_write_n`  out  1  active-low write.
- `m_writedata`  out  16  write data.
- `m_waitrequest`  in  1  slave stall; tie to 0 when the slave has none.
- `tick`  out  1  one-cycle pulse per serviced timeout.
- `tick_count`  out  32  number of ticks since reset; wraps 0xFFFFFFFF→0.
- `running`  out  1  high only in RUN.

## Operation
- Register map driven: 0 = status (write clears timeout), 1 = control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 = period_l, 3 = period_h.
- Only writes are issued; the block never reads.
- States: IDLE, WR_STOP, WR_PERL, WR_PERH, WR_CTRL, RUN, WR_STAT, SETTLE.
- Transitions:
  - IDLE→WR_PERL when `enable`.
  - WR_PERL→WR_PERH→WR_CTRL→RUN, each on write acceptance.
  - RUN→WR_STAT when `timer_irq`.
  - WR_STAT→SETTLE on acceptance; `tick` pulses and `tick_count` increments in the SETTLE cycle.
  - SETTLE→RUN.
  - RUN→WR_STOP when `!enable`; WR_STOP→IDLE on acceptance.
  - RUN→WR_STOP when a reprogram is pending; WR_STOP→WR_PERL on acceptance.
- Write data per state:
  - WR_STOP: 0x0008.
  - WR_PERL: period[15:0].
  - WR_PERH: period[31:16].
  - WR_CTRL: 0x0007.
  - WR_STAT: 0x0000.
- Period register: loads `PERIOD` at reset. On `cfg_load` in any state it loads `cfg_period` and sets `pend`; a later `cfg_load` overwrites the value (last wins). `pend` clears on entering WR_PERL.
- RUN priority: `timer_irq` > `!enable` > `pend`.
- Reprogramming from IDLE: `pend` with `enable` low stays pending; the new value is used at the next start.
- Multiple timeouts before the status clear merge into one tick. This is a documented limitation; no overrun flag.
- SETTLE exists because the timer's irq falls one cycle after the status write. `timer_irq` is ignored in SETTLE.

## Timing
- Reset values:
  - `m_chipselect` 0, `m_write_n` 1, `m_address` 0, `m_writedata` 0.
  - `tick` 0, `tick_count` 0, `running` 0.
  - State IDLE, `pend` 0.
- All outputs are registered (Moore); bus signals change only on `clk` edges.
- Handshake:
  - A write is presented with `m_chipselect`=1, `m_write_n`=0.
  - It is held stable while `m_waitrequest`=1.
  - It completes at the edge where `m_waitrequest`=0.
  - Bus signals return idle in the next cycle unless the next state is also a write.
- Startup, zero wait states: `enable` sampled high at edge k. WR_PERL is on the bus in cycle k+1, WR_PERH in k+2, WR_CTRL in k+3, and `running`=1 from k+4.
- Service, zero wait states: `timer_irq` sampled high at edge n. WR_STAT is on the bus in n+1, `tick`=1 in n+2, and RUN resumes in n+3.
- Each wait-state cycle adds exactly one cycle to the latencies above.
- Reset mid-write: the bus idles immediately (asynchronous), and the full sequence restarts after release.

## Structure
- Shared package `led_sandbox_systick_pkg`:
  - register address constants (STATUS, CONTROL, PERIODL, PERIODH);
  - control bit positions (ITO, CONT, START, STOP);
  - the state enumeration.
- Single module; no sub-module is warranted.

## Test plan
- Boot, `PERIOD`=49999, `enable`=1, no wait states → writes (2,0xC34F), (3,0x0000), (1,0x0007) on consecutive cycles; `running`=1 one cycle after the last write.
- `timer_irq` asserted in RUN → write (0,0x0000) next cycle; `tick` one cycle later; `tick_count` 0→1; no second write while irq falls.
- `m_waitrequest` held high 3 cycles on WR_PERH → address/data stable for 4 cycles; WR_CTRL follows the accepting edge.
- `cfg_load` with 0x000186A0 in RUN → (1,0x0008), (2,0x86A0), (3,0x0001), (1,0x0007); then `cfg_load` and `timer_irq` in the same cycle → status write and tick first, then the reprogram sequence.
- `enable` dropped in RUN → (1,0x0008), then IDLE with `running`=0; re-enable → full start sequence with the latched period.
- `reset_n` asserted during WR_PERL with `m_waitrequest`=1 → bus idle immediately, `tick_count`=0; after release, the sequence restarts from WR_PERL.

Source files
------------

// File: rtl/led_sandbox_systick_pkg.sv
// Shared definitions for the systick sequencer: timer register map,
// control bit positions and the sequencer state encoding.
package led_sandbox_systick_pkg;

  localparam logic [2:0] STATUS  = 3'd0;
  localparam logic [2:0] CONTROL = 3'd1;
  localparam logic [2:0] PERIODL = 3'd2;
  localparam logic [2:0] PERIODH = 3'd3;

  localparam int ITO   = 0;
  localparam int CONT  = 1;
  localparam int START = 2;
  localparam int STOP  = 3;

  localparam logic [15:0] CTRL_GO   = 16'((1 << ITO) | (1 << CONT) | (1 << START));
  localparam logic [15:0] CTRL_HALT = 16'(1 << STOP);

  typedef enum logic [2:0] {
    IDLE, WR_STOP, WR_PERL, WR_PERH, WR_CTRL, RUN, WR_STAT, SETTLE
  } state_t;

  function automatic logic is_write(state_t s);
    case (s)
      WR_STOP, WR_PERL, WR_PERH, WR_CTRL, WR_STAT: is_write = 1'b1;
      default:                                     is_write = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/led_sandbox_systick_sequencer.sv
// Avalon-MM write-only master that programs, starts, services and
// reprograms the systick interval timer, emitting one tick per timeout.
module led_sandbox_systick_sequencer
  import led_sandbox_systick_pkg::*;
#(
  parameter logic [31:0] PERIOD = 32'd49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] cfg_period,
  input  logic        cfg_load,
  input  logic        timer_irq,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [15:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic        running
);

  state_t      state, state_nxt;
  logic [31:0] period, period_nxt;
  logic        pend, pend_nxt;
  logic        stall;
  logic [2:0]  addr_nxt;
  logic [15:0] data_nxt;

  assign stall = is_write(state) && m_waitrequest;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = WR_PERL;
      WR_STOP: if (!m_waitrequest) state_nxt = (pend && enable) ? WR_PERL : IDLE;
      WR_PERL: if (!m_waitrequest) state_nxt = WR_PERH;
      WR_PERH: if (!m_waitrequest) state_nxt = WR_CTRL;
      WR_CTRL: if (!m_waitrequest) state_nxt = RUN;
      RUN: begin
        if (timer_irq)    state_nxt = WR_STAT;
        else if (!enable) state_nxt = WR_STOP;
        else if (pend)    state_nxt = WR_STOP;
      end
      WR_STAT: if (!m_waitrequest) state_nxt = SETTLE;
      // irq is still high here for one cycle after the status clear
      SETTLE:  state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    period_nxt = cfg_load ? cfg_period : period;
    pend_nxt   = pend;
    if (cfg_load)
      pend_nxt = 1'b1;
    else if (state_nxt == WR_PERL && state != WR_PERL)
      pend_nxt = 1'b0;
  end

  always_comb begin
    addr_nxt = 3'd0;
    data_nxt = 16'h0000;
    case (state_nxt)
      WR_STOP: begin addr_nxt = CONTROL; data_nxt = CTRL_HALT;          end
      WR_PERL: begin addr_nxt = PERIODL; data_nxt = period_nxt[15:0];   end
      WR_PERH: begin addr_nxt = PERIODH; data_nxt = period_nxt[31:16];  end
      WR_CTRL: begin addr_nxt = CONTROL; data_nxt = CTRL_GO;            end
      WR_STAT: begin addr_nxt = STATUS;  data_nxt = 16'h0000;           end
      default: begin addr_nxt = 3'd0;    data_nxt = 16'h0000;           end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      period <= PERIOD;
      pend   <= 1'b0;
    end else begin
      state  <= state_nxt;
      period <= period_nxt;
      pend   <= pend_nxt;
    end
  end

  // Bus outputs are frozen while the slave stalls so address/data stay stable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= 3'd0;
      m_writedata  <= 16'h0000;
    end else if (!stall) begin
      m_chipselect <= is_write(state_nxt);
      m_write_n    <= !is_write(state_nxt);
      m_address    <= addr_nxt;
      m_writedata  <= data_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick       <= 1'b0;
      tick_count <= 32'd0;
      running    <= 1'b0;
    end else begin
      tick    <= (state_nxt == SETTLE);
      running <= (state_nxt == RUN);
      if (state_nxt == SETTLE) tick_count <= tick_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_led_sandbox_systick_sequencer.sv
// Directed bench: stimulus pushes expected bus writes and ticks into
// queues; a negedge monitor pops and compares what the DUT presents.
module tb_led_sandbox_systick_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] cfg_period;
  logic        cfg_load;
  logic        timer_irq;
  logic [2:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [15:0] m_writedata;
  logic        m_waitrequest;
  logic        tick;
  logic [31:0] tick_count;
  logic        running;

  int n_tests = 0;
  int n_fail  = 0;

  logic [18:0] wq[$];   // {address, data}
  logic [31:0] tq[$];   // tick_count expected with each tick

  always #5 clk = ~clk;

  led_sandbox_systick_sequencer #(.PERIOD(32'd49999)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_period(cfg_period),
    .cfg_load(cfg_load), .timer_irq(timer_irq), .m_address(m_address),
    .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest), .tick(tick),
    .tick_count(tick_count), .running(running)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_w(input logic [2:0] a, input logic [15:0] d);
    wq.push_back({a, d});
  endtask

  task automatic drain(input string name);
    int c = 0;
    while ((wq.size() != 0 || tq.size() != 0) && c < 60) begin
      cyc(1);
      c++;
    end
    chk({name, "_drain_timeout"}, (c >= 60) ? 32'd1 : 32'd0, 32'd0);
  endtask

  // Monitor: a write counts when presented with waitrequest low
  logic        prev_stall = 1'b0;
  logic [18:0] prev_w     = '0;
  always @(negedge clk) begin
    logic [18:0] exp_w;
    logic [31:0] exp_t;
    if (reset_n) begin
      if (m_chipselect && !m_write_n) begin
        if (prev_stall) chk("stall_stable", {13'd0, m_address, m_writedata}, {13'd0, prev_w});
        if (!m_waitrequest) begin
          if (wq.size() == 0) begin
            chk("unexpected_write", {13'd0, m_address, m_writedata}, 32'hFFFF_FFFF);
          end else begin
            exp_w = wq.pop_front();
            chk("write", {13'd0, m_address, m_writedata}, {13'd0, exp_w});
          end
        end
        prev_stall = m_waitrequest;
        prev_w     = {m_address, m_writedata};
      end else begin
        prev_stall = 1'b0;
      end
      if (tick) begin
        if (tq.size() == 0) begin
          chk("unexpected_tick", tick_count, 32'hFFFF_FFFF);
        end else begin
          exp_t = tq.pop_front();
          chk("tick_count", tick_count, exp_t);
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; cfg_period = 32'd0; cfg_load = 1'b0;
    timer_irq = 1'b0; m_waitrequest = 1'b0;
    cyc(3);
    chk("rst_cs",      {31'd0, m_chipselect}, 32'd0);
    chk("rst_write_n", {31'd0, m_write_n},    32'd1);
    chk("rst_addr",    {29'd0, m_address},    32'd0);
    chk("rst_data",    {16'd0, m_writedata},  32'd0);
    chk("rst_tick",    {31'd0, tick},         32'd0);
    chk("rst_count",   tick_count,            32'd0);
    chk("rst_running", {31'd0, running},      32'd0);
    reset_n = 1'b1;
    cyc(2);
    chk("idle_no_write", {31'd0, m_chipselect}, 32'd0);

    // Boot: consecutive PERL/PERH/CTRL, running the cycle after
    push_w(3'd2, 16'hC34F); push_w(3'd3, 16'h0000); push_w(3'd1, 16'h0007);
    enable = 1'b1;
    cyc(1); chk("boot_c1_addr", {29'd0, m_address}, 32'd2);
    cyc(1); chk("boot_c2_addr", {29'd0, m_address}, 32'd3);
    cyc(1); chk("boot_c3_addr", {29'd0, m_address}, 32'd1);
    chk("boot_c3_running", {31'd0, running}, 32'd0);
    cyc(1); chk("boot_running", {31'd0, running}, 32'd1);
    chk("boot_bus_idle", {31'd0, m_chipselect}, 32'd0);

    // Service: irq stays high through SETTLE and must be ignored there
    push_w(3'd0, 16'h0000); tq.push_back(32'd1);
    timer_irq = 1'b1;
    cyc(1); chk("svc_stat_addr", {29'd0, m_address}, 32'd0);
    chk("svc_stat_cs", {31'd0, m_chipselect}, 32'd1);
    cyc(1); chk("svc_tick", {31'd0, tick}, 32'd1);
    chk("svc_count", tick_count, 32'd1);
    cyc(1); timer_irq = 1'b0;
    chk("svc_running", {31'd0, running}, 32'd1);
    chk("svc_tick_low", {31'd0, tick}, 32'd0);
    cyc(4);
    chk("svc_no_extra", {31'd0, m_chipselect}, 32'd0);

    // Reprogram with a 3-cycle stall on PERH
    push_w(3'd1, 16'h0008); push_w(3'd2, 16'h86A0);
    push_w(3'd3, 16'h0001); push_w(3'd1, 16'h0007);
    cfg_period = 32'h0001_86A0; cfg_load = 1'b1;
    cyc(1); cfg_load = 1'b0;
    cyc(3); chk("ws_perh_addr", {29'd0, m_address}, 32'd3);
    m_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("ws_hold_addr", {29'd0, m_address}, 32'd3);
      chk("ws_hold_data", {16'd0, m_writedata}, 32'h0001);
    end
    m_waitrequest = 1'b0;
    cyc(1); chk("ws_ctrl_addr", {29'd0, m_address}, 32'd1);
    chk("ws_ctrl_data", {16'd0, m_writedata}, 32'h0007);
    cyc(1); chk("ws_running", {31'd0, running}, 32'd1);

    // cfg_load and irq together: status clear and tick come first
    push_w(3'd0, 16'h0000); tq.push_back(32'd2);
    push_w(3'd1, 16'h0008); push_w(3'd2, 16'h0003);
    push_w(3'd3, 16'h0002); push_w(3'd1, 16'h0007);
    cfg_period = 32'h0002_0003; cfg_load = 1'b1; timer_irq = 1'b1;
    cyc(1); cfg_load = 1'b0;
    chk("both_stat_first", {29'd0, m_address}, 32'd0);
    cyc(1); timer_irq = 1'b0;
    chk("both_tick", {31'd0, tick}, 32'd1);
    drain("both");
    chk("both_running", {31'd0, running}, 32'd1);

    // Disable, then reprogram while idle; value used at next start
    push_w(3'd1, 16'h0008);
    enable = 1'b0;
    drain("dis");
    cyc(2);
    chk("dis_running", {31'd0, running}, 32'd0);
    cfg_period = 32'h0000_1234; cfg_load = 1'b1;
    cyc(1); cfg_load = 1'b0;
    cyc(3);
    chk("idle_pend_no_write", {31'd0, m_chipselect}, 32'd0);
    push_w(3'd2, 16'h1234); push_w(3'd3, 16'h0000); push_w(3'd1, 16'h0007);
    enable = 1'b1;
    drain("reen");
    chk("reen_running", {31'd0, running}, 32'd1);

    // Reset while WR_PERL is stalled
    push_w(3'd1, 16'h0008);
    enable = 1'b0;
    drain("dis2");
    cyc(2);
    enable = 1'b1; m_waitrequest = 1'b1;
    cyc(1); chk("mid_perl_addr", {29'd0, m_address}, 32'd2);
    cyc(2);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cs",      {31'd0, m_chipselect}, 32'd0);
    chk("mid_rst_write_n", {31'd0, m_write_n},    32'd1);
    chk("mid_rst_count",   tick_count,            32'd0);
    cyc(2);
    m_waitrequest = 1'b0;
    push_w(3'd2, 16'hC34F); push_w(3'd3, 16'h0000); push_w(3'd1, 16'h0007);
    reset_n = 1'b1;
    cyc(1); chk("restart_perl", {29'd0, m_address}, 32'd2);
    drain("restart");
    chk("restart_running", {31'd0, running}, 32'd1);

    cyc(3);
    chk("final_wq_empty", wq.size(), 32'd0);
    chk("final_tq_empty", tq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
